// File: rtl/mem_req_xbar.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_xbar
// Brief    : Parametrised req/gnt crossbar with per-slave round-robin,
//            response routing and an internal decode-error responder.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_xbar #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NB_MASTER-1:0]             m_req_i,
  output logic [NB_MASTER-1:0]             m_gnt_o,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NB_MASTER-1:0]             m_we_i,
  input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0]  m_wdata_i,
  output logic [NB_MASTER-1:0]             m_rvalid_o,
  output logic [NB_MASTER*DATA_WIDTH-1:0]  m_rdata_o,
  output logic [NB_MASTER-1:0]             m_err_o,
  output logic [NB_SLAVE-1:0]              s_req_o,
  input  logic [NB_SLAVE-1:0]              s_gnt_i,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]   s_addr_o,
  output logic [NB_SLAVE-1:0]              s_we_o,
  output logic [NB_SLAVE*DATA_WIDTH/8-1:0] s_be_o,
  output logic [NB_SLAVE*DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [NB_SLAVE-1:0]              s_rvalid_i,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0]   s_rdata_i,
  input  logic [NB_SLAVE-1:0]              s_err_i,
  output logic [7:0]                       dec_err_cnt_o,
  output logic [ADDR_WIDTH-1:0]            dec_err_addr_o
);

  localparam int C_BE_WIDTH = DATA_WIDTH / 8;
  localparam int C_MIDX_W   = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int C_SIDX_W   = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  logic [NB_SLAVE-1:0]   r_busy;
  logic [C_MIDX_W-1:0]   r_owner  [NB_SLAVE];
  logic [C_MIDX_W-1:0]   r_rr_ptr [NB_SLAVE];
  logic [NB_MASTER-1:0]  r_pending;
  logic [NB_MASTER-1:0]  r_derr;
  logic [7:0]            r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic [NB_MASTER-1:0]  w_hit;
  logic [NB_MASTER-1:0]  w_elig;
  logic [NB_MASTER-1:0]  w_derr_gnt;
  logic [C_SIDX_W-1:0]   w_sel [NB_MASTER];
  logic [NB_SLAVE-1:0]   w_found;
  logic [C_MIDX_W-1:0]   w_win [NB_SLAVE];
  logic [9:0]            w_cnt_sum;
  logic [ADDR_WIDTH-1:0] w_err_addr;

  // Scan regions high to low so the lowest matching index wins on overlap.
  always_comb begin
    for (int m = 0; m < NB_MASTER; m++) begin
      w_hit[m] = 1'b0;
      w_sel[m] = '0;
      for (int k = NB_SLAVE - 1; k >= 0; k--) begin
        if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] &&
            m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
          w_hit[m] = 1'b1;
          w_sel[m] = C_SIDX_W'(k);
        end
      end
      w_elig[m]     = m_req_i[m] & ~r_pending[m] & ~r_derr[m];
      w_derr_gnt[m] = w_elig[m] & ~w_hit[m];
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < NB_SLAVE; k++) begin
      w_found[k] = 1'b0;
      w_win[k]   = '0;
      if (!r_busy[k]) begin
        for (int i = 0; i < NB_MASTER; i++) begin
          idx = int'(r_rr_ptr[k]) + i;
          if (idx >= NB_MASTER) idx = idx - NB_MASTER;
          if (!w_found[k] && w_elig[idx] && w_hit[idx] && w_sel[idx] == C_SIDX_W'(k)) begin
            w_found[k] = 1'b1;
            w_win[k]   = C_MIDX_W'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    m_gnt_o    = w_derr_gnt;
    m_rvalid_o = r_derr;
    m_err_o    = r_derr;
    m_rdata_o  = '0;
    s_req_o    = '0;
    s_addr_o   = '0;
    s_we_o     = '0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    for (int k = 0; k < NB_SLAVE; k++) begin
      if (w_found[k]) begin
        s_req_o[k]                             = 1'b1;
        s_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]   = m_addr_i[int'(w_win[k])*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o[k]                              = m_we_i[w_win[k]];
        s_be_o[k*C_BE_WIDTH +: C_BE_WIDTH]     = m_be_i[int'(w_win[k])*C_BE_WIDTH +: C_BE_WIDTH];
        s_wdata_o[k*DATA_WIDTH +: DATA_WIDTH]  = m_wdata_i[int'(w_win[k])*DATA_WIDTH +: DATA_WIDTH];
        m_gnt_o[w_win[k]]                      = s_gnt_i[k];
      end
      // Responses from an idle slave are dropped here.
      if (r_busy[k] && s_rvalid_i[k]) begin
        m_rvalid_o[r_owner[k]]                             = 1'b1;
        m_err_o[r_owner[k]]                                = s_err_i[k];
        m_rdata_o[int'(r_owner[k])*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_cnt_sum  = {2'b00, r_err_cnt};
    w_err_addr = r_err_addr;
    for (int m = 0; m < NB_MASTER; m++) begin
      if (w_derr_gnt[m]) begin
        w_cnt_sum  = w_cnt_sum + 10'd1;
        w_err_addr = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_pending  <= '0;
      r_derr     <= '0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      for (int k = 0; k < NB_SLAVE; k++) begin
        r_owner[k]  <= '0;
        r_rr_ptr[k] <= '0;
      end
    end else begin
      r_derr     <= w_derr_gnt;
      r_err_cnt  <= (w_cnt_sum > 10'd255) ? 8'hFF : w_cnt_sum[7:0];
      r_err_addr <= w_err_addr;
      for (int k = 0; k < NB_SLAVE; k++) begin
        if (r_busy[k] && s_rvalid_i[k]) begin
          r_busy[k]             <= 1'b0;
          r_pending[r_owner[k]] <= 1'b0;
        end else if (w_found[k] && s_gnt_i[k]) begin
          r_busy[k]           <= 1'b1;
          r_owner[k]          <= w_win[k];
          r_pending[w_win[k]] <= 1'b1;
          r_rr_ptr[k]         <= (w_win[k] == C_MIDX_W'(NB_MASTER - 1)) ? '0 : w_win[k] + 1'b1;
        end
      end
    end
  end

  assign dec_err_cnt_o  = r_err_cnt;
  assign dec_err_addr_o = r_err_addr;

endmodule
`default_nettype wire
